// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: default sizing, the measurement
// FSM state type and a helper that builds the LED pattern for a stuck line.
package pwm_duty_meter_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // waiting for a reference rising edge
    ST_MEAS_HIGH = 2'd1,  // line high, timing the high phase
    ST_MEAS_LOW  = 2'd2   // line low, waiting for the rise that closes the period
  } meas_state_e;

  // A stuck line shows as all LEDs on (stuck high) or all off (stuck low).
  function automatic logic [7:0] led_fill(input logic level);
    return level ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/pwm_duty_meter_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous line into the clk domain through a
// two-flop synchronizer and produces single-cycle rise/fall pulses by comparing
// the synchronized level with its previous value. No glitch filtering.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset (clears all flops to 0)
//   async_i  in  asynchronous input line
//   level_o  out synchronized level
//   rise_o   out 1-cycle pulse on a synchronized 0->1 transition
//   fall_o   out 1-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and rise-to-rise period of an external
// PWM line in clk cycles, publishes each complete period with a 1-cycle strobe,
// flags a line with no edges for TIMEOUT_CYC cycles as stuck, and drives an
// 8-LED duty thermometer.
// Ports:
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   pwm_in       in  asynchronous PWM input
//   high_cnt     out high time of the last complete period (cycles)
//   period_cnt   out rise-to-rise length of the last complete period (cycles)
//   meas_valid   out 1-cycle pulse when high_cnt/period_cnt update
//   stuck        out no edge seen for TIMEOUT_CYC cycles
//   stuck_level  out synchronized line level captured when stuck asserted
//   led          out duty thermometer, led[i] lit when duty > i/8
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [7:0]       led
);

  localparam int unsigned      EW        = CNT_W + 3;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  logic sync_lvl;
  logic rise;
  logic fall;
  logic any_edge;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pwm_in),
    .level_o (sync_lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign any_edge = rise | fall;

  meas_state_e      state_q;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [CNT_W-1:0] high_latch_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W:0]   period_sum;
  logic             mv_q;
  logic             stuck_q;
  logic             stuck_prev_q;
  logic             stuck_lvl_q;
  logic [7:0]       led_q;
  logic [7:0]       thermo;

  // Cycles since the last edge; restarts at 1 on every edge and parks at the
  // timeout value so the stuck condition stays true while the line is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (any_edge) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TIMEOUT_V) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The counter restarts on the falling edge too, so the rise-to-rise period
  // is the latched high time plus the low time counted at the closing rise.
  // Saturate rather than wrap if the sum outgrows CNT_W.
  assign period_sum = {1'b0, high_latch_q} + {1'b0, cnt_q};
  assign period_d   = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];

  // led[i] lit when high/period > i/8, i.e. 8*high > i*period, in CNT_W+3 bits.
  always_comb begin
    thermo = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      thermo[i] = ({high_q, 3'b000} > (EW'(i) * {3'b000, period_q}));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      high_latch_q <= '0;
      high_q       <= '0;
      period_q     <= '0;
      mv_q         <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_prev_q <= 1'b0;
      stuck_lvl_q  <= 1'b0;
      led_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      mv_q         <= 1'b0;
      stuck_prev_q <= stuck_q;

      // An edge always takes priority over the timeout in the same cycle.
      if (any_edge) begin
        unique case (state_q)
          ST_IDLE: begin
            if (rise) state_q <= ST_MEAS_HIGH;
          end
          ST_MEAS_HIGH: begin
            // A rise here can only follow a missed fall; it just restarts
            // the reference, so the state is unchanged.
            if (fall) begin
              high_latch_q <= cnt_q;
              state_q      <= ST_MEAS_LOW;
            end
          end
          ST_MEAS_LOW: begin
            if (rise) begin
              high_q   <= high_latch_q;
              period_q <= period_d;
              mv_q     <= 1'b1;
              stuck_q  <= 1'b0;
              state_q  <= ST_MEAS_HIGH;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (cnt_q == TIMEOUT_V) begin
        stuck_q     <= 1'b1;
        stuck_lvl_q <= sync_lvl;
        state_q     <= ST_IDLE;
      end

      // LEDs follow a fresh measurement, or the onset of a stuck line.
      if (mv_q) begin
        led_q <= thermo;
      end else if (stuck_q && !stuck_prev_q) begin
        led_q <= led_fill(stuck_lvl_q);
      end
    end
  end

  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign meas_valid  = mv_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;
  assign led         = led_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter. The reference model works on the waveform the bench
// drives: each driven edge is timestamped, periods are derived from the gaps
// between edges, and each expected publish is scheduled a fixed pipeline delay
// after the rise that closes a period. Every cycle all outputs are compared.
module tb_pwm_duty_meter;

  localparam int unsigned CNT_W = 16;
  localparam int          TO    = 64;
  localparam int          LAT   = 3;   // driven edge -> strobe, in clk cycles

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;
  logic [7:0]       led;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .led         (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int h;
    int p;
  } pub_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc  = 0;

  pub_t pq[$];
  bit   in_rst;
  bit   lvl;
  bit   have_ref;
  int   last_edge;
  int   last_high;

  bit         exp_mv;
  int         exp_hi;
  int         exp_per;
  bit         exp_stuck;
  bit         exp_slvl;
  logic [7:0] exp_led;
  bit         led_pend;
  logic [7:0] led_pend_val;

  function automatic logic [7:0] thermo(input int h, input int p);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (8 * h > i * p);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, ncyc, obs, exp);
    end
  endtask

  task automatic cyc();
    pub_t e;
    @(posedge clk);
    #1;
    ncyc++;
    exp_mv = 1'b0;
    if (!in_rst) begin
      if (led_pend) begin
        exp_led  = led_pend_val;
        led_pend = 1'b0;
      end
      if (pq.size() != 0 && pq[0].due == ncyc) begin
        e            = pq.pop_front();
        exp_mv       = 1'b1;
        exp_hi       = e.h;
        exp_per      = e.p;
        exp_stuck    = 1'b0;
        led_pend     = 1'b1;
        led_pend_val = thermo(e.h, e.p);
      end else if (ncyc - last_edge >= TO + LAT) begin
        if (!exp_stuck) begin
          led_pend     = 1'b1;
          led_pend_val = lvl ? 8'hFF : 8'h00;
        end
        exp_stuck = 1'b1;
        exp_slvl  = lvl;
      end
    end
    chk("meas_valid",  32'(meas_valid),  32'(exp_mv));
    chk("high_cnt",    32'(high_cnt),    32'(exp_hi));
    chk("period_cnt",  32'(period_cnt),  32'(exp_per));
    chk("stuck",       32'(stuck),       32'(exp_stuck));
    chk("stuck_level", 32'(stuck_level), 32'(exp_slvl));
    chk("led",         32'(led),         32'(exp_led));
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  // Drive a new line level and update the period model from the edge gaps.
  task automatic set_lvl(input bit v);
    int gap;
    gap = ncyc - last_edge;
    if (v != lvl) begin
      if (gap > TO) have_ref = 1'b0;   // line timed out before this edge
      if (v) begin
        if (have_ref) pq.push_back('{ncyc + LAT, last_high, last_high + gap});
        have_ref = 1'b1;
      end else begin
        last_high = gap;
      end
      lvl       = v;
      last_edge = ncyc;
      pwm_in    = v;
    end
  endtask

  task automatic period(input int h, input int l);
    set_lvl(1'b1);
    hold(h);
    set_lvl(1'b0);
    hold(l);
  endtask

  task automatic close_period();
    set_lvl(1'b1);
    hold(6);
  endtask

  task automatic do_reset(input int n, input bit lvl_after);
    rst_n     = 1'b0;
    in_rst    = 1'b1;
    pq.delete();
    have_ref  = 1'b0;
    exp_mv    = 1'b0;
    exp_hi    = 0;
    exp_per   = 0;
    exp_stuck = 1'b0;
    exp_slvl  = 1'b0;
    exp_led   = '0;
    led_pend  = 1'b0;
    pwm_in    = lvl_after;
    lvl       = lvl_after;
    hold(n);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    // A line already high at release shows up as a rise; a low line just
    // lets the idle count start from zero.
    if (lvl) begin
      last_edge = ncyc;
      have_ref  = 1'b1;
    end else begin
      last_edge = ncyc - 2;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    lvl    = 1'b0;

    // Reset state, then 4/12 periods (led 8'h03)
    do_reset(3, 1'b0);
    hold(5);
    repeat (3) period(4, 12);
    close_period();

    // 8/8 (led 8'h0F), then 12/4 (led 8'h3F)
    repeat (3) period(8, 8);
    repeat (3) period(12, 4);
    close_period();
    set_lvl(1'b0);
    hold(6);

    // Line high straight out of reset: stuck high, then recover with 4/12
    do_reset(3, 1'b1);
    hold(75);
    set_lvl(1'b0);
    hold(12);
    repeat (3) period(4, 12);
    close_period();

    // Minimum pulses: 1/1 -> strobe every 2 cycles
    repeat (12) period(1, 1);
    close_period();

    // Reset in the middle of a low phase; partial period discarded
    repeat (2) period(4, 12);
    set_lvl(1'b1);
    hold(4);
    set_lvl(1'b0);
    hold(5);
    do_reset(2, 1'b0);
    hold(3);
    repeat (3) period(5, 11);
    close_period();

    // Line held low after valid data: stuck low, values retained
    set_lvl(1'b0);
    hold(70);

    // Phases exactly at the timeout length do not trip stuck
    repeat (3) period(TO, TO);
    close_period();

    // Randomized periods
    for (int k = 0; k < 40; k++) begin
      period(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
    end
    close_period();
    set_lvl(1'b0);
    hold(8);

    chk("publish_queue_drained", 32'(pq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
